uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one 9N1 `uart_tx` serializer among `NUM_REQ` independent requesters. Each requester offers a 9-bit word with a valid/ready handshake. The arbiter selects one requester, issues a single-cycle `send` with the latched word to `uart_tx`, and tracks the serializer's `ready` until the frame completes. It then pulses a per-requester done flag. It sits between the controller's message sources and the single UART transmit line.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: word width and the
// arbiter state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request bit found
// searching upward from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic            found;
  logic [ID_W-1:0] pos;

  // Walk the ring starting just after the previous winner; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 9N1 uart_tx serializer among NUM_REQ
// requesters. Each accepted word is issued with a one-cycle send, the
// serializer's ready is tracked through the frame, and a per-requester done
// pulse follows once the frame has left the line.
// Optional build macro UART_ARB_PRIO0_EN: requester 0 gets strict priority,
// the other requesters share the remaining slots round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           send,
  output logic [UART_DATA_W-1:0]         data,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      last_grant;
  logic [NUM_REQ-1:0]   rr_req;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic [ID_W-1:0]      rr_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_W-1:0]      win_id;
  logic                 grant_en;
  logic                 done_en;

`ifdef UART_ARB_PRIO0_EN
  // Requester 0 is taken out of the ring and overrides it whenever valid.
  assign rr_req = {req_valid[NUM_REQ-1:1], 1'b0};
  assign win_oh = req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_gnt;
  assign win_id = req_valid[0] ? '0 : rr_idx;
`else
  assign rr_req = req_valid;
  assign win_oh = rr_gnt;
  assign win_id = rr_idx;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req  (rr_req),
    .last (last_grant),
    .gnt  (rr_gnt),
    .idx  (rr_idx)
  );

  // Next-state and handshake decode; grants happen only from IDLE with the
  // serializer idle, so req_ready is at most one bit and only in IDLE.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    done_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_ready && (|req_valid)) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: if (!tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_ready) begin
          done_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  assign req_ready = grant_en ? win_oh : '0;
  assign send      = (state == ISSUE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Latch the winning word and index on grant; advance the ring and pulse
  // done when the frame completes. last_grant starts at the top so
  // requester 0 is first in line after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_done   <= '0;
    end else begin
      if (grant_en) begin
        data     <= req_data[UART_DATA_W*win_id +: UART_DATA_W];
        grant_id <= win_id;
      end
      if (done_en) last_grant <= grant_id;
      req_done <= done_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized frames, checked against a transaction-level model that keeps
// the requesters in a rotating line-up queue.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 9;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_done;
  logic           send;
  logic [W-1:0]   data;
  logic           tx_ready;
  logic           busy;
  logic [1:0]     grant_id;

  int             n_chk = 0;
  int             n_err = 0;
  int             order[$];
  logic [N-1:0]   exp_done;
  logic [W-1:0]   words[N];
  bit             scramble;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .send      (send),
    .data      (data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-up: front of the queue is next in turn; last granted sits at the back.
  task automatic model_reset();
    order = {};
    for (int i = 0; i < N; i++) order.push_back(i);
  endtask

  task automatic model_done(input int w);
    for (int i = 0; i < N && order[$] != w; i++) order.push_back(order.pop_front());
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
`ifdef UART_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    foreach (order[i]) if (v[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Advance one cycle: drive after the edge, sample at the falling edge.
  task automatic cyc(input logic [N-1:0] v, input logic t);
    @(posedge clock);
    #1;
    req_valid = v;
    tx_ready  = t;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
    @(negedge clock);
    chk("req_done", req_done, exp_done);
    exp_done = '0;
  endtask

  task automatic in_frame(input logic [W-1:0] word, input int w, input logic sending);
    chk("frame_send", send, sending);
    chk("frame_data", data, word);
    chk("frame_gid", grant_id, w);
    chk("frame_busy", busy, 1);
    chk("frame_ready", req_ready, 0);
  endtask

  // One complete transaction with a serializer stub driving tx_ready.
  task automatic frame(input logic [N-1:0] v, input int gap, input logic gap_busy,
                       input logic keep, input logic [N-1:0] pulse, output int w);
    logic [W-1:0] word;
    logic [N-1:0] nv;
    int s, l;
    for (int g = 0; g < gap; g++) begin
      if (gap_busy) cyc(v, 1'b0);
      else          cyc('0, 1'b1);
      chk("idle_ready", req_ready, 0);
      chk("idle_send", send, 0);
      chk("idle_busy", busy, 0);
    end
    cyc(v, 1'b1);
    w = model_pick(v);
    chk("accept_ready", req_ready, onehot(w));
    chk("accept_busy", busy, 0);
    chk("accept_send", send, 0);
    word = words[w];
    if (scramble) for (int i = 0; i < N; i++) words[i] = W'($urandom);
    nv = keep ? v : (v & ~onehot(w));
    cyc(nv | pulse, 1'b1);
    in_frame(word, w, 1'b1);
    s = $urandom_range(0, 2);
    l = $urandom_range(1, 5);
    for (int i = 0; i < s; i++) begin cyc(nv, 1'b1); in_frame(word, w, 1'b0); end
    for (int i = 0; i < l; i++) begin cyc(nv, 1'b0); in_frame(word, w, 1'b0); end
    cyc(nv, 1'b1);
    in_frame(word, w, 1'b0);
    exp_done = onehot(w);
    model_done(w);
  endtask

  initial begin
    int w, exp_w;
    logic [N-1:0] v;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    exp_done  = '0;
    scramble  = 1'b0;
    for (int i = 0; i < N; i++) words[i] = '0;
    model_reset();
    #1;
    chk("rst_send", send, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single request on requester 2.
    words[2] = 9'h155;
    frame(4'b0100, 1, 1'b0, 1'b0, '0, w);
    chk("single_gid", w, 2);

    // Withdrawn request: requester 1 pulses valid during a frame only.
    frame(4'b0001, 1, 1'b0, 1'b0, 4'b0010, w);

    // Serializer busy: valid held while tx_ready is low, no grant.
    frame(4'b0001, 4, 1'b1, 1'b0, '0, w);

    // Reset during WAIT_DONE.
    cyc('0, 1'b1);
    cyc(4'b0100, 1'b1);
    w = model_pick(4'b0100);
    chk("rst_accept", req_ready, onehot(w));
    cyc('0, 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk("midrst_send", send, 0);
    chk("midrst_data", data, 0);
    chk("midrst_done", req_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gid", grant_id, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    cyc('0, 1'b1);
    cyc('0, 1'b1);

    // Full contention from reset, all valid held, fixed words.
    for (int i = 0; i < N; i++) words[i] = W'(i + 1);
    for (int k = 0; k < 5; k++) begin
      frame(4'b1111, 0, 1'b0, 1'b1, '0, w);
`ifdef UART_ARB_PRIO0_EN
      exp_w = 0;
`else
      exp_w = k % N;
`endif
      chk("rotate_gid", w, exp_w);
    end

    // Randomized traffic.
    scramble = 1'b1;
    for (int k = 0; k < 60; k++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      frame(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            N'($urandom), w);
    end
    cyc('0, 1'b1);
    chk("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
